// File: rtl/hwpe_stream_downsizer.sv
// HWPE-Stream width converter: splits each wide push word into RATIO narrow pop beats,
// LSB slice first, optionally skipping slices whose byte strobe is all-zero.
module hwpe_stream_downsizer #(
   parameter int unsigned IN_WIDTH   = 32,
   parameter int unsigned OUT_WIDTH  = 8,
   parameter bit          SKIP_EMPTY = 1'b0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clear_i,
   input  logic [IN_WIDTH-1:0]    push_data_i,
   input  logic [IN_WIDTH/8-1:0]  push_strb_i,
   input  logic                   push_valid_i,
   output logic                   push_ready_o,
   output logic [OUT_WIDTH-1:0]   pop_data_o,
   output logic [OUT_WIDTH/8-1:0] pop_strb_o,
   output logic                   pop_valid_o,
   input  logic                   pop_ready_i,
   output logic                   busy_o
);

   localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
   localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int unsigned ISW   = IN_WIDTH / 8;
   localparam int unsigned OSW   = OUT_WIDTH / 8;

   if (RATIO < 2 || (IN_WIDTH % OUT_WIDTH) != 0 || (OUT_WIDTH % 8) != 0) begin : gen_param_err
      $error("hwpe_stream_downsizer: invalid IN_WIDTH/OUT_WIDTH combination");
   end

   logic [IN_WIDTH-1:0] word_data_q, word_data_d;
   logic [ISW-1:0]      word_strb_q, word_strb_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                full_q, full_d;

   logic [RATIO-1:0]    nz_cur, nz_new;
   logic                next_found, first_found;
   logic [IDX_W-1:0]    next_idx, first_idx;
   logic                last_beat;
   logic                pop_hs, push_hs;

   // A slice is eligible for emission if skipping is off or its strobe has any bit set.
   always_comb begin
      nz_cur = '0;
      nz_new = '0;
      for (int k = 0; k < int'(RATIO); k++) begin
         nz_cur[k] = SKIP_EMPTY ? |word_strb_q[k*OSW +: OSW] : 1'b1;
         nz_new[k] = SKIP_EMPTY ? |push_strb_i[k*OSW +: OSW] : 1'b1;
      end
   end

   // Priority encoders: downward scan so the lowest qualifying index is the one kept.
   always_comb begin
      next_found  = 1'b0;
      next_idx    = '0;
      first_found = 1'b0;
      first_idx   = '0;
      for (int k = int'(RATIO) - 1; k >= 0; k--) begin
         if (k > int'(idx_q) && nz_cur[k]) begin
            next_found = 1'b1;
            next_idx   = IDX_W'(k);
         end
         if (nz_new[k]) begin
            first_found = 1'b1;
            first_idx   = IDX_W'(k);
         end
      end
   end

   assign last_beat    = ~next_found;
   assign pop_hs       = full_q & pop_ready_i;
   assign push_ready_o = ~full_q | (pop_hs & last_beat);
   assign push_hs      = push_valid_i & push_ready_o;

   always_comb begin
      word_data_d = word_data_q;
      word_strb_d = word_strb_q;
      idx_d       = idx_q;
      full_d      = full_q;
      if (pop_hs) begin
         if (last_beat) begin
            full_d = 1'b0;
            idx_d  = '0;
         end else begin
            idx_d = next_idx;
         end
      end
      // A word with nothing to emit is consumed and the block stays empty.
      if (push_hs) begin
         word_data_d = push_data_i;
         word_strb_d = push_strb_i;
         full_d      = first_found;
         idx_d       = first_found ? first_idx : '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         word_data_q <= '0;
         word_strb_q <= '0;
         idx_q       <= '0;
         full_q      <= 1'b0;
      end else begin
         word_data_q <= word_data_d;
         word_strb_q <= word_strb_d;
         idx_q       <= idx_d;
         full_q      <= full_d;
      end
   end

   assign pop_valid_o = full_q;
   assign pop_data_o  = full_q ? word_data_q[32'(idx_q) * OUT_WIDTH +: OUT_WIDTH] : '0;
   assign pop_strb_o  = full_q ? word_strb_q[32'(idx_q) * OSW +: OSW] : '0;
   assign busy_o      = full_q;

endmodule

// File: doc/hwpe_stream_downsizer.md
# hwpe_stream_downsizer

Synchronous HWPE-Stream width converter that accepts one wide word on its push port and emits it as `IN_WIDTH/OUT_WIDTH` narrower beats, LSB slice first, on its pop port. It sits directly downstream of `hwpe_stream_fifo` and drains it toward a narrower consumer (narrow memory port or serial link). It is fully backpressure-aware and sustains back-to-back words without bubbles. Optionally it drops slices whose byte strobe is all-zero.

## Interface
- `IN_WIDTH`, default 32: push data width in bits; must be a multiple of `OUT_WIDTH` and of 8.
- `OUT_WIDTH`, default 8: pop data width in bits; must be a multiple of 8.
- `SKIP_EMPTY`, default 0: when 1, slices with all-zero strobe are not emitted.
- Derived: `RATIO = IN_WIDTH/OUT_WIDTH`, at least 2 (elaboration error otherwise). `IDX_W = $clog2(RATIO)`.
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `clear_i`  in  1  synchronous active-high clear; same effect as `rst_i`.
- `push_i`  slave `hwpe_stream_intf_stream`  `IN_WIDTH` data, `IN_WIDTH/8` strb  wide input stream.
- `pop_o`  master `hwpe_stream_intf_stream`  `OUT_WIDTH` data, `OUT_WIDTH/8` strb  narrow output stream.
- `busy_o`  out  1  high while a word is held and not fully emitted.

## Operation
- Holding register: `word_q` (data and strb), `idx_q` (IDX_W bits), `full_q`.
- State EMPTY (`full_q=0`): `push_i.ready=1`. A push handshake loads `word_q`, sets `idx_q` to the first emitted slice, and goes to SERIAL.
- State SERIAL (`full_q=1`):
  - `pop_o.valid=1`.
  - `pop_o.data = word_q.data[idx_q*OUT_WIDTH +: OUT_WIDTH]`; `pop_o.strb` is the matching strb slice.
  - On a pop handshake, `idx_q` advances to the next emitted slice.
- Last beat: the pop handshake on the final emitted slice.
  - `push_i.ready = ~full_q | (pop_o.valid & pop_o.ready & last)`.
  - A push on the last-beat cycle reloads `word_q` directly and stays in SERIAL.
  - Without a push, the block returns to EMPTY.
- Slice selection:
  - With `SKIP_EMPTY=0`, slices are emitted 0, 1, …, RATIO-1, and the first slice is 0.
  - With `SKIP_EMPTY=1`, the first and next slices are the lowest-index slice at or above the candidate index whose strb slice is nonzero, found by a priority encoder.
  - A word with all-zero strb is accepted (ready=1 in EMPTY or on a last beat) and discarded. State becomes or stays EMPTY, and no beat is emitted.
- Stream rules:
  - `pop_o.valid` never drops without a handshake.
  - `pop_o.data` and `pop_o.strb` are stable while valid and not ready.
  - `push_i` data is sampled only on a handshake.
- `busy_o = full_q`.

## Timing
- Reset and clear values: `full_q=0`, `idx_q=0`, `word_q=0`. Outputs: `pop_o.valid=0`, `pop_o.data=0`, `pop_o.strb=0`, `push_i.ready=1`, `busy_o=0`.
- Reset and clear win over any simultaneous handshake. A word in flight is lost, and the next cycle is EMPTY.
- Latency: the first beat is valid on the cycle after the push handshake. There is no combinational path from `push_i` data to `pop_o`.
- `push_i.ready` depends combinationally on `pop_o.ready`. This is the only combinational through-path.
- Throughput: with `pop_o.ready=1`, there is exactly one pop per cycle and RATIO pops per word (fewer with skipping), with no idle cycle between words.
- Backpressure: while `pop_o.ready=0`, `idx_q` and `word_q` hold and `push_i.ready=0` (if full).
- `idx_q` never wraps past RATIO-1. After the last beat it reloads from the new word, or stays at 0 when going EMPTY.

## Test plan
- Reset, then push 0x44332211 (strb 0xF) with ready=1 -> pops 0x11, 0x22, 0x33, 0x44 on consecutive cycles starting 1 cycle after the push. `busy_o` is high for 4 cycles.
- Push 0xAABBCCDD then 0x01020304 back-to-back, ready=1 -> 8 consecutive pops DD, CC, BB, AA, 04, 03, 02, 01. Second push ready=1 exactly on the AA cycle.
- Hold `pop_o.ready=0` for 5 cycles mid-word at slice 2 -> valid=1, data=slice 2 constant, `push_i.ready=0`. Release -> emission resumes at slice 2.
- `SKIP_EMPTY=1`, push 0x00FF00EE with strb 0b0101 -> pops only 0xEE (strb 1) and 0xFF (strb 1). Push with strb 0 -> accepted, no pop, `busy_o` stays 0.
- Assert `rst_i` (or `clear_i`) at slice 1 while a push is also pending -> next cycle valid=0, ready=1, `busy_o=0`. A subsequent push 0x0A0B0C0D emits 0D first.
- Random stall (10 % gen, 10 % recv) with 1024 words fed through `hwpe_stream_fifo` into this block -> output beat sequence equals the golden LSB-first serialization; no loss or duplication.
